// File: rtl/sram_cmd_parser_if.sv
`default_nettype none
// ============================================================================
//  Module   : sram_cmd_parser_if
//  Brief    : UART byte streams and SRAM macro port bundled for sram_cmd_parser.
//  Revision : 1.0  initial release
// ============================================================================
interface sram_cmd_parser_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              rx_enable;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              tx_enable;
  logic              sram_csb;
  logic              sram_web;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_din;
  logic [DATA_W-1:0] sram_dout;

  modport master (
    input  rx_data, rx_valid, tx_ready, sram_dout,
    output rx_ready, rx_enable, tx_data, tx_valid, tx_enable,
           sram_csb, sram_web, sram_addr, sram_din
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, sram_dout,
    input  rx_ready, rx_enable, tx_data, tx_valid, tx_enable,
           sram_csb, sram_web, sram_addr, sram_din
  );
endinterface
`default_nettype wire

// File: rtl/sram_cmd_parser.sv
`default_nettype none
// ============================================================================
//  Module   : sram_cmd_parser
//  Brief    : Assembles UART bytes into SRAM read/write frames, answers with
//             ACK or read data. Define CHECKSUM_EN for XOR-checked frames.
//  Revision : 1.0  initial release
// ============================================================================
module sram_cmd_parser #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 1,
  parameter int TIMEOUT  = 65535
) (
  input  logic              clk,
  input  logic              reset,
  sram_cmd_parser_if.master bus,
  output logic              busy,
  output logic              frame_err
);

  localparam int         CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [7:0] ACK_BYTE = 8'h06;
`ifdef CHECKSUM_EN
  localparam logic [7:0] NAK_BYTE = 8'h15;
  localparam logic [2:0] LAST_TX  = 3'd4;
`else
  localparam logic [2:0] LAST_TX  = 3'd3;
`endif

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_DATA  = 4'd1,
    S_WRITE = 4'd2,
    S_READ  = 4'd3,
    S_WAIT  = 4'd4,
    S_SEND  = 4'd5,
    S_ACK   = 4'd6
`ifdef CHECKSUM_EN
    , S_CSUM = 4'd7
`endif
  } state_t;

  state_t            r_state;
  state_t            w_state_next;

  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_din;
  logic [DATA_W-1:0] r_word;
  logic [7:0]        r_ack;
  logic [2:0]        r_byte_cnt;
  logic [1:0]        r_lat;
  logic [CNT_W-1:0]  r_tmo;
  logic              r_frame_err;

  logic              w_rx_ready;
  logic              w_rx_take;
  logic              w_in_csum;
  logic              w_in_frame;
  logic              w_tmo_hit;
  logic              w_lat_done;
  logic              w_tx_valid;
  logic [7:0]        w_tx_data;
  logic [7:0]        w_tx_tail;
  logic              w_csb;
  logic              w_web;

`ifdef CHECKSUM_EN
  logic [7:0]        r_cmd;
  logic              w_csum_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cmd <= 8'h00;
    end else if (r_state == S_IDLE && w_rx_take) begin
      r_cmd <= bus.rx_data;
    end
  end

  // Checksum covers the full command byte, reserved bits included.
  assign w_csum_ok = (bus.rx_data == (r_cmd ^ r_din[7:0] ^ r_din[15:8] ^ r_din[23:16] ^ r_din[31:24]));
  assign w_tx_tail = r_cmd ^ r_word[7:0] ^ r_word[15:8] ^ r_word[23:16] ^ r_word[31:24];
  assign w_in_csum = (r_state == S_CSUM);
`else
  assign w_tx_tail = 8'h00;
  assign w_in_csum = 1'b0;
`endif

  assign w_rx_ready = (r_state == S_IDLE) || (r_state == S_DATA) || w_in_csum;
  assign w_rx_take  = bus.rx_valid && w_rx_ready;
  assign w_in_frame = (r_state == S_DATA) || w_in_csum;
  assign w_tmo_hit  = w_in_frame && !w_rx_take && (r_tmo == CNT_W'(TIMEOUT - 1));
  assign w_lat_done = (r_lat == 2'(READ_LAT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_tx_valid   = 1'b0;
    w_tx_data    = 8'h00;
    w_csb        = 1'b1;
    w_web        = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (w_rx_take) begin
          w_state_next = bus.rx_data[7] ? S_DATA : S_READ;
        end
      end
      S_DATA: begin
        if (w_rx_take) begin
          if (r_byte_cnt == 3'd3) begin
`ifdef CHECKSUM_EN
            w_state_next = S_CSUM;
`else
            w_state_next = S_WRITE;
`endif
          end
        end else if (w_tmo_hit) begin
          w_state_next = S_IDLE;
        end
      end
`ifdef CHECKSUM_EN
      S_CSUM: begin
        if (w_rx_take) begin
          w_state_next = w_csum_ok ? S_WRITE : S_ACK;
        end else if (w_tmo_hit) begin
          w_state_next = S_IDLE;
        end
      end
`endif
      S_WRITE: begin
        w_csb        = 1'b0;
        w_web        = 1'b0;
        w_state_next = S_ACK;
      end
      S_READ: begin
        w_csb        = 1'b0;
        w_state_next = S_WAIT;
      end
      S_WAIT: begin
        if (w_lat_done) begin
          w_state_next = S_SEND;
        end
      end
      S_SEND: begin
        w_tx_valid = 1'b1;
        case (r_byte_cnt)
          3'd0:    w_tx_data = r_word[7:0];
          3'd1:    w_tx_data = r_word[15:8];
          3'd2:    w_tx_data = r_word[23:16];
          3'd3:    w_tx_data = r_word[31:24];
          default: w_tx_data = w_tx_tail;
        endcase
        if (bus.tx_ready && r_byte_cnt == LAST_TX) begin
          w_state_next = S_IDLE;
        end
      end
      S_ACK: begin
        w_tx_valid = 1'b1;
        w_tx_data  = r_ack;
        if (bus.tx_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr      <= '0;
      r_din       <= '0;
      r_word      <= '0;
      r_ack       <= 8'h00;
      r_byte_cnt  <= 3'd0;
      r_lat       <= 2'd0;
      r_frame_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_rx_take) begin
            r_addr      <= bus.rx_data[ADDR_W-1:0];
            r_frame_err <= 1'b0;
            r_byte_cnt  <= 3'd0;
          end
        end
        S_DATA: begin
          if (w_rx_take) begin
            case (r_byte_cnt[1:0])
              2'd0:    r_din[7:0]   <= bus.rx_data;
              2'd1:    r_din[15:8]  <= bus.rx_data;
              2'd2:    r_din[23:16] <= bus.rx_data;
              default: r_din[31:24] <= bus.rx_data;
            endcase
            r_byte_cnt <= r_byte_cnt + 3'd1;
          end else if (w_tmo_hit) begin
            r_frame_err <= 1'b1;
          end
        end
`ifdef CHECKSUM_EN
        S_CSUM: begin
          if (w_rx_take && !w_csum_ok) begin
            r_frame_err <= 1'b1;
            r_ack       <= NAK_BYTE;
          end else if (w_tmo_hit) begin
            r_frame_err <= 1'b1;
          end
        end
`endif
        S_WRITE: r_ack <= ACK_BYTE;
        S_READ:  r_lat <= 2'd0;
        S_WAIT: begin
          r_lat <= r_lat + 2'd1;
          if (w_lat_done) begin
            r_word     <= bus.sram_dout;
            r_byte_cnt <= 3'd0;
          end
        end
        S_SEND: begin
          if (bus.tx_ready) begin
            r_byte_cnt <= r_byte_cnt + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Inter-byte idle counter; only meaningful while a write frame is open.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tmo <= '0;
    end else if (w_rx_take || !w_in_frame) begin
      r_tmo <= '0;
    end else begin
      r_tmo <= r_tmo + CNT_W'(1);
    end
  end

  assign bus.rx_ready  = w_rx_ready;
  assign bus.rx_enable = 1'b1;
  assign bus.tx_enable = 1'b1;
  assign bus.tx_valid  = w_tx_valid;
  assign bus.tx_data   = w_tx_data;
  assign bus.sram_csb  = w_csb;
  assign bus.sram_web  = w_web;
  assign bus.sram_addr = r_addr;
  assign bus.sram_din  = r_din;
  assign busy          = (r_state != S_IDLE);
  assign frame_err     = r_frame_err;

endmodule
`default_nettype wire
